load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side memory access controller for the MEM stage of the pipelined core. It accepts one load or store per instruction from the pipeline and converts the byte address and funct3 width into a word-addressed, byte-enabled request on the data-memory port. Loads are returned lane-extracted and sign/zero-extended. The unit stalls the pipeline until the access completes, and rejects misaligned or illegal-width accesses without issuing any memory request.

## Interface
- DM_ADDRESS, 9, word-address width of the data-memory port
- DATA_W, 32, data width; fixed at 32, four byte lanes
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- mem_en  in  1  MEM stage holds a load/store this cycle
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
- addr  in  32  byte address from ALU
- wdata  in  DATA_W  store data (rs2)
- stall  out  1  hold IF/ID/EX/MEM registers
- done  out  1  one-cycle pulse: access complete
- rdata  out  DATA_W  formatted load data; valid when done=1 for a load
- fault  out  1  misaligned or illegal-funct3 access (combinational, IDLE only)
- dm_req  out  1  request to data memory
- dm_we  out  1  request is a write
- dm_addr  out  DM_ADDRESS  word address = latched addr[DM_ADDRESS+1:2]
- dm_be  out  4  byte enables
- dm_wdata  out  DATA_W  lane-replicated store data
- dm_gnt  in  1  memory accepted request this cycle
- dm_rvalid  in  1  read data valid; never in the same cycle as the matching dm_gnt
- dm_rdata  in  DATA_W  raw read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if mem_en and legal -> latch addr, wdata, funct3, mem_we; go REQ. If mem_en and illegal -> fault=1, no latch, no request, stay IDLE.
- Illegal access: funct3 in {011,110,111}; funct3 in {011,100,101,110,111} with mem_we=1; half with addr[0]=1; word with addr[1:0]!=00.
- REQ: dm_req=1, all dm_* driven from latched registers and stable until dm_gnt. On dm_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT: dm_req=0. On dm_rvalid, format dm_rdata into the rdata register and go to DONE.
- DONE: done=1 and stall=0. Go to IDLE. mem_en is ignored in DONE because that cycle still carries the same instruction.
- Store formatting, with off = addr[1:0]:
  - SB: dm_be = 0001<<off; dm_wdata = {4{wdata[7:0]}}.
  - SH: dm_be = 0011<<off; dm_wdata = {2{wdata[15:0]}}.
  - SW: dm_be = 1111; dm_wdata = wdata.
- Load formatting:
  - Byte lane = dm_rdata[8*off+7 : 8*off].
  - Half = dm_rdata[16*off[1]+15 : 16*off[1]].
  - LB/LH sign-extend from the MSB of the extracted field, not from bit 31 of the word.
  - LBU/LHU zero-extend.
- Stores leave rdata unchanged.
- dm_we=0 and dm_be=0000 whenever dm_req=0.

## Timing
- stall = (IDLE & mem_en & legal) | REQ | WAIT. The IDLE term is combinational, so the pipeline freezes in the acceptance cycle.
- Minimum latency, with dm_gnt in the first REQ cycle:
  - Store: accept T, REQ T+1, DONE T+2.
  - Load with dm_rvalid at T+2: WAIT T+2, DONE T+3.
- No upper bound on gnt/rvalid wait; the unit stalls indefinitely.
- Back-to-back accesses: the next instruction is seen in IDLE at DONE+1. There is always at least one IDLE cycle between requests.
- dm_rvalid in IDLE/REQ/DONE, or dm_gnt outside REQ, is ignored.
- Reset values: state=IDLE, stall=0, done=0, fault=0, rdata=0, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0.
- Reset mid-transaction: abort at the sampling edge and return to IDLE. dm_req is low from the next cycle, and a late dm_rvalid is discarded. The memory shares the same reset.

## Test plan
- SW addr=0x0000_0104, wdata=0xDEAD_BEEF, gnt immediate -> dm_addr=0x041, dm_be=1111, dm_wdata=0xDEADBEEF, stall high 2 cycles, done at T+2.
- SB addr=0x0000_0013, wdata=0x0000_00A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5; SH addr=0x...12, wdata=0x1234 -> dm_be=1100, dm_wdata=0x12341234.
- Loads with dm_rdata=0x80FF_7F01:
  - LB off=1 -> 0x0000007F.
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
- dm_gnt delayed 3 cycles, then dm_rvalid 2 cycles after gnt -> dm_req/dm_addr stable throughout, stall continuous, done exactly one cycle, rdata correct.
- LW addr=0x...102, SH addr=0x...001, funct3=011 -> fault=1 same cycle, stall=0, dm_req never asserted.
- Reset asserted in WAIT, then dm_rvalid arrives -> state IDLE, done never pulses, rdata=0, stall=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/response bus between load_store_unit and data memory
interface load_store_unit_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  dm_req;
    logic                  dm_we;
    logic [DM_ADDRESS-1:0] dm_addr;
    logic [3:0]            dm_be;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store controller: alignment check, lane formatting, pipeline stall
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    load_store_unit_if.master dm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Only the word-address bits and the byte offset are ever needed after acceptance.
    logic [DM_ADDRESS+1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic                  legal;
    logic                  accept;
    logic [1:0]            off_q;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_W-1:0]     load_fmt;
    logic [3:0]            be_fmt;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr[31:DM_ADDRESS+2];
    assign off_q = addr_q[1:0];

    // Legality of the incoming access: width encoding, store-only widths and natural alignment.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~mem_we;
            3'b101:  legal = ~mem_we & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; gnt and rvalid only matter in the state that waits for them.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en && legal) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dm.dm_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dm.dm_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the instruction on acceptance so the bus stays stable while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else if (accept) begin
            addr_q   <= addr[DM_ADDRESS+1:0];
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= mem_we;
        end
    end

    // Store byte enables and lane-replicated write data from the latched access.
    always_comb begin
        be_fmt = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   be_fmt = 4'b0001 << off_q;
            2'b01:   be_fmt = 4'b0011 << off_q;
            default: be_fmt = 4'b1111;
        endcase
    end

    // Load lane extraction; sign comes from the extracted field, not from bit 31 of the word.
    always_comb begin
        byte_lane = dm.dm_rdata[7:0];
        case (off_q)
            2'd0: byte_lane = dm.dm_rdata[7:0];
            2'd1: byte_lane = dm.dm_rdata[15:8];
            2'd2: byte_lane = dm.dm_rdata[23:16];
            2'd3: byte_lane = dm.dm_rdata[31:24];
            default: byte_lane = dm.dm_rdata[7:0];
        endcase
        half_lane = off_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_fmt = {24'd0, byte_lane};
            3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_fmt = {16'd0, half_lane};
            default: load_fmt = dm.dm_rdata;
        endcase
    end

    // Load result register; stores and ignored rvalids leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (state_q == WAIT && dm.dm_rvalid) begin
            rdata <= load_fmt;
        end
    end

    // Pipeline-facing status and memory-side request outputs.
    always_comb begin
        stall       = (state_q == REQ) || (state_q == WAIT) || (state_q == IDLE && mem_en && legal);
        fault       = (state_q == IDLE) && mem_en && !legal;
        done        = (state_q == DONE);
        dm.dm_req   = (state_q == REQ);
        dm.dm_we    = (state_q == REQ) && we_q;
        dm.dm_be    = (state_q == REQ) ? be_fmt : 4'b0000;
        dm.dm_addr  = addr_q[DM_ADDRESS+1:2];
        case (funct3_q[1:0])
            2'b00:   dm.dm_wdata = {4{wdata_q[7:0]}};
            2'b01:   dm.dm_wdata = {2{wdata_q[15:0]}};
            default: dm.dm_wdata = wdata_q;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    int          checks;
    int          failures;

    load_store_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) dm_bus ();

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_en (mem_en),
        .mem_we (mem_we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .stall  (stall),
        .done   (done),
        .rdata  (rdata),
        .fault  (fault),
        .dm     (dm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        mem_en = 1'b1;
        mem_we = we;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        #1;
        check({tag, ".acc_stall"}, 32'(stall), 32'd1);
        check({tag, ".acc_fault"}, 32'(fault), 32'd0);
        check({tag, ".acc_req"}, 32'(dm_bus.dm_req), 32'd0);
        for (int i = 0; i <= gnt_dly; i++) begin
            tick();
            dm_bus.dm_gnt = (i == gnt_dly);
            #1;
            check({tag, ".req"}, 32'(dm_bus.dm_req), 32'd1);
            check({tag, ".we"}, 32'(dm_bus.dm_we), 32'(we));
            check({tag, ".addr"}, 32'(dm_bus.dm_addr), 32'(a[10:2]));
            check({tag, ".be"}, 32'(dm_bus.dm_be), 32'(exp_be));
            if (we) check({tag, ".wdata"}, dm_bus.dm_wdata, exp_wd);
            check({tag, ".req_stall"}, 32'(stall), 32'd1);
            check({tag, ".req_done"}, 32'(done), 32'd0);
        end
        tick();
        dm_bus.dm_gnt = 1'b0;
        if (!we) begin
            for (int i = 0; i <= rv_dly; i++) begin
                dm_bus.dm_rvalid = (i == rv_dly);
                #1;
                check({tag, ".wait_req"}, 32'(dm_bus.dm_req), 32'd0);
                check({tag, ".wait_be"}, 32'(dm_bus.dm_be), 32'd0);
                check({tag, ".wait_stall"}, 32'(stall), 32'd1);
                check({tag, ".wait_done"}, 32'(done), 32'd0);
                tick();
            end
            dm_bus.dm_rvalid = 1'b0;
        end
        #1;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".done_stall"}, 32'(stall), 32'd0);
        check({tag, ".done_req"}, 32'(dm_bus.dm_req), 32'd0);
        check({tag, ".rdata"}, rdata, exp_rd);
        mem_en = 1'b0;
        tick();
        #1;
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic bad_access(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        mem_en = 1'b1;
        mem_we = we;
        funct3 = f3;
        addr   = a;
        wdata  = 32'hFFFF_FFFF;
        dm_bus.dm_gnt = 1'b1;
        #1;
        check({tag, ".fault"}, 32'(fault), 32'd1);
        check({tag, ".stall"}, 32'(stall), 32'd0);
        check({tag, ".req"}, 32'(dm_bus.dm_req), 32'd0);
        tick();
        #1;
        check({tag, ".req_next"}, 32'(dm_bus.dm_req), 32'd0);
        check({tag, ".fault_held"}, 32'(fault), 32'd1);
        mem_en = 1'b0;
        dm_bus.dm_gnt = 1'b0;
        #1;
        check({tag, ".fault_clear"}, 32'(fault), 32'd0);
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        mem_en = 1'b0;
        mem_we = 1'b0;
        funct3 = 3'b000;
        addr = 32'd0;
        wdata = 32'd0;
        dm_bus.dm_gnt = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        dm_bus.dm_rdata = 32'd0;
        tick();
        tick();
        #1;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.req", 32'(dm_bus.dm_req), 32'd0);
        check("rst.we", 32'(dm_bus.dm_we), 32'd0);
        check("rst.be", 32'(dm_bus.dm_be), 32'd0);
        check("rst.addr", 32'(dm_bus.dm_addr), 32'd0);
        check("rst.wdata", dm_bus.dm_wdata, 32'd0);
        reset = 1'b0;
        tick();

        access("sw", 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("sb", 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("sh", 1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 0, 0, 4'b1100, 32'h1234_1234, 32'h0);

        dm_bus.dm_rdata = 32'h80FF_7F01;
        access("lb1",  1'b0, 3'b000, 32'h0000_0201, 32'h0, 0, 0, 4'b0010, 32'h0, 32'h0000_007F);
        access("lb2",  1'b0, 3'b000, 32'h0000_0202, 32'h0, 0, 0, 4'b0100, 32'h0, 32'hFFFF_FFFF);
        access("lbu3", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 0, 4'b1000, 32'h0, 32'h0000_0080);
        access("lh2",  1'b0, 3'b001, 32'h0000_0202, 32'h0, 0, 0, 4'b1100, 32'h0, 32'hFFFF_80FF);
        access("lhu0", 1'b0, 3'b101, 32'h0000_0200, 32'h0, 0, 0, 4'b0011, 32'h0, 32'h0000_7F01);
        access("lw",   1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h80FF_7F01);

        access("sw_keep", 1'b1, 3'b010, 32'h0000_0008, 32'h0102_0304, 0, 0, 4'b1111, 32'h0102_0304, 32'h80FF_7F01);

        access("slow_lhu", 1'b0, 3'b101, 32'h0000_03FE, 32'h0, 3, 1, 4'b1100, 32'h0, 32'h0000_80FF);

        bad_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
        bad_access("sh_mis", 1'b1, 3'b001, 32'h0000_0001);
        bad_access("f3_011", 1'b0, 3'b011, 32'h0000_0000);
        bad_access("sbu",    1'b1, 3'b100, 32'h0000_0000);

        mem_en = 1'b1;
        mem_we = 1'b0;
        funct3 = 3'b000;
        addr   = 32'h0000_0201;
        tick();
        dm_bus.dm_gnt = 1'b1;
        tick();
        dm_bus.dm_gnt = 1'b0;
        mem_en = 1'b0;
        #1;
        check("rstw.in_wait", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dm_bus.dm_rvalid = 1'b1;
        #1;
        check("rstw.stall", 32'(stall), 32'd0);
        check("rstw.done", 32'(done), 32'd0);
        check("rstw.req", 32'(dm_bus.dm_req), 32'd0);
        check("rstw.rdata", rdata, 32'd0);
        tick();
        dm_bus.dm_rvalid = 1'b0;
        #1;
        check("rstw.done_late", 32'(done), 32'd0);
        check("rstw.rdata_late", rdata, 32'd0);
        check("rstw.stall_late", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
